// File: rtl/triangle_assembler_pkg.sv
// rtl/triangle_assembler_pkg.sv - shared graphics constants, assembler states and saturation helper
package triangle_assembler_pkg;

    localparam int          SCREEN_W  = 640;
    localparam int          SCREEN_H  = 480;
    localparam logic [31:0] FLOAT_ONE = 32'h3f800000;

    typedef enum logic [3:0] {
        IDLE, UPD, UPD_WAIT, FETCH, READ, XFORM, XFORM_WAIT, STORE, CULL, EMIT, FIN
    } asm_state_t;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/triangle_assembler_tri_cull.sv
// rtl/triangle_assembler_tri_cull.sv - coordinate saturation plus frustum and facing test
module tri_cull #(
    parameter int CULL_BACK = 1
) (
    input  logic [31:0]        raw_x,
    input  logic [31:0]        raw_y,
    output logic signed [15:0] sat_x,
    output logic signed [15:0] sat_y,
    input  logic signed [15:0] x0,
    input  logic signed [15:0] y0,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] y2,
    output logic               reject
);
    import triangle_assembler_pkg::*;

    localparam logic signed [15:0] X_MAX = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_MAX = 16'(SCREEN_H - 1);

    logic               all_left, all_right, all_above, all_below, frustum;
    logic signed [16:0] dx1, dy1, dx2, dy2;
    logic signed [34:0] area;

    assign sat_x = sat16($signed(raw_x));
    assign sat_y = sat16($signed(raw_y));

    assign all_left  = x0[15] && x1[15] && x2[15];
    assign all_above = y0[15] && y1[15] && y2[15];
    assign all_right = (x0 > X_MAX) && (x1 > X_MAX) && (x2 > X_MAX);
    assign all_below = (y0 > Y_MAX) && (y1 > Y_MAX) && (y2 > Y_MAX);
    assign frustum   = all_left || all_right || all_above || all_below;

    assign dx1  = $signed({x1[15], x1}) - $signed({x0[15], x0});
    assign dy1  = $signed({y1[15], y1}) - $signed({y0[15], y0});
    assign dx2  = $signed({x2[15], x2}) - $signed({x0[15], x0});
    assign dy2  = $signed({y2[15], y2}) - $signed({y0[15], y0});
    assign area = 35'(dx1) * 35'(dy2) - 35'(dx2) * 35'(dy1);

    // With y pointing down, a clockwise (front) triangle has positive area; degenerate ones are dropped.
    assign reject = frustum || ((CULL_BACK != 0) && (area <= 35'sd0));

endmodule

// File: rtl/triangle_assembler.sv
// rtl/triangle_assembler.sv - fetches vertices, drives the transform stage, culls and emits triangles
module triangle_assembler #(
    parameter int NUM_TRIS  = 12,
    parameter int ADDR_W    = 8,
    parameter int CULL_BACK = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    output logic               busy,
    output logic               frame_done,
    output logic [ADDR_W-1:0]  vert_addr,
    input  logic [31:0]        vert_x,
    input  logic [31:0]        vert_y,
    input  logic [31:0]        vert_z,
    output logic               mvp_start,
    output logic               mvp_update,
    output logic [31:0]        mvp_x,
    output logic [31:0]        mvp_y,
    output logic [31:0]        mvp_z,
    input  logic               mvp_done,
    input  logic [31:0]        mvp_ox,
    input  logic [31:0]        mvp_oy,
    input  logic [31:0]        mvp_oz,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic signed [15:0] tri_x0,
    output logic signed [15:0] tri_y0,
    output logic signed [15:0] tri_x1,
    output logic signed [15:0] tri_y1,
    output logic signed [15:0] tri_x2,
    output logic signed [15:0] tri_y2
);
    import triangle_assembler_pkg::*;

    localparam int TRI_W = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;

    asm_state_t         state, next_state;
    logic [TRI_W-1:0]   tri_idx;
    logic [1:0]         k;
    logic               wait_first, last_tri, reject, advance;
    logic signed [15:0] sat_x, sat_y, v0x, v0y, v1x, v1y, v2x, v2y;
    logic               unused_oz;

    assign unused_oz = ^mvp_oz;

    tri_cull #(.CULL_BACK(CULL_BACK)) u_cull (
        .raw_x (mvp_ox), .raw_y (mvp_oy),
        .sat_x (sat_x),  .sat_y (sat_y),
        .x0 (v0x), .y0 (v0y), .x1 (v1x), .y1 (v1y), .x2 (v2x), .y2 (v2y),
        .reject (reject)
    );

    assign vert_addr  = ADDR_W'(32'(tri_idx) * 32'd3 + 32'(k));
    assign last_tri   = (tri_idx == TRI_W'(NUM_TRIS - 1));
    assign advance    = ((state == CULL) && reject) || ((state == EMIT) && tri_ready);
    assign busy       = (state != IDLE);
    assign frame_done = (state == FIN);
    assign tri_valid  = (state == EMIT);

    // Requests are only issued into an idle transform stage, so a start may wait here.
    always_comb begin
        next_state = state;
        mvp_start  = 1'b0;
        mvp_update = 1'b0;
        case (state)
            IDLE:       if (frame_start) next_state = UPD;
            UPD: begin
                mvp_start  = mvp_done;
                mvp_update = mvp_done;
                if (mvp_done) next_state = UPD_WAIT;
            end
            UPD_WAIT:   if (!wait_first && mvp_done) next_state = (NUM_TRIS == 0) ? FIN : FETCH;
            FETCH:      next_state = READ;
            READ:       next_state = XFORM;
            XFORM: begin
                mvp_start = mvp_done;
                if (mvp_done) next_state = XFORM_WAIT;
            end
            XFORM_WAIT: if (!wait_first && mvp_done) next_state = STORE;
            STORE:      next_state = (k == 2'd2) ? CULL : FETCH;
            CULL:       next_state = reject ? (last_tri ? FIN : FETCH) : EMIT;
            EMIT:       if (tri_ready) next_state = last_tri ? FIN : FETCH;
            FIN:        next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tri_idx    <= '0;
            k          <= '0;
            wait_first <= 1'b0;
            mvp_x      <= '0;
            mvp_y      <= '0;
            mvp_z      <= '0;
            v0x <= '0; v0y <= '0; v1x <= '0; v1y <= '0; v2x <= '0; v2y <= '0;
            tri_x0 <= '0; tri_y0 <= '0; tri_x1 <= '0; tri_y1 <= '0; tri_x2 <= '0; tri_y2 <= '0;
        end else begin
            state      <= next_state;
            wait_first <= (state == UPD) || (state == XFORM);
            if (state == IDLE && frame_start) begin
                tri_idx <= '0;
                k       <= '0;
            end
            if (state == READ) begin
                mvp_x <= vert_x;
                mvp_y <= vert_y;
                mvp_z <= vert_z;
            end
            if (state == STORE) begin
                case (k)
                    2'd0:    begin v0x <= sat_x; v0y <= sat_y; end
                    2'd1:    begin v1x <= sat_x; v1y <= sat_y; end
                    default: begin v2x <= sat_x; v2y <= sat_y; end
                endcase
                if (k != 2'd2) k <= k + 2'd1;
            end
            if (state == CULL && !reject) begin
                tri_x0 <= v0x; tri_y0 <= v0y;
                tri_x1 <= v1x; tri_y1 <= v1y;
                tri_x2 <= v2x; tri_y2 <= v2y;
            end
            if (advance) begin
                k <= '0;
                if (!last_tri) tri_idx <= tri_idx + TRI_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_triangle_assembler.sv
// tb/tb_triangle_assembler.sv - scoreboard bench for triangle_assembler
module tb_triangle_assembler;

    localparam int NT     = 7;
    localparam int XF_LAT = 6;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset = 1'b1, frame_start = 1'b0, frame_start0 = 1'b0, tri_ready = 1'b1;
    logic               busy, frame_done, mvp_start, mvp_update, mvp_done, tri_valid;
    logic [7:0]         vert_addr;
    logic [31:0]        vert_x = '0, vert_y = '0, vert_z = '0;
    logic [31:0]        mvp_x, mvp_y, mvp_z;
    logic [31:0]        xf_ox = '0, xf_oy = '0, xf_oz = '0;
    logic signed [15:0] tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
    logic [95:0]        tri_obs;

    logic               busy0, frame_done0, mvp_start0, mvp_update0, mvp_done0, tri_valid0;
    logic [7:0]         vert_addr0;
    logic [31:0]        mvp_x0, mvp_y0, mvp_z0;
    logic signed [15:0] t0_x0, t0_y0, t0_x1, t0_y1, t0_x2, t0_y2;

    int xf_cnt = 0, xf0_cnt = 0;
    assign mvp_done  = (xf_cnt == 0);
    assign mvp_done0 = (xf0_cnt == 0);
    assign tri_obs   = {tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2};

    triangle_assembler #(.NUM_TRIS(NT), .ADDR_W(8), .CULL_BACK(1)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
        .vert_addr(vert_addr), .vert_x(vert_x), .vert_y(vert_y), .vert_z(vert_z),
        .mvp_start(mvp_start), .mvp_update(mvp_update), .mvp_x(mvp_x), .mvp_y(mvp_y), .mvp_z(mvp_z),
        .mvp_done(mvp_done), .mvp_ox(xf_ox), .mvp_oy(xf_oy), .mvp_oz(xf_oz),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1), .tri_y1(tri_y1), .tri_x2(tri_x2), .tri_y2(tri_y2)
    );

    triangle_assembler #(.NUM_TRIS(0), .ADDR_W(8), .CULL_BACK(1)) dut0 (
        .clock(clock), .reset(reset), .frame_start(frame_start0), .busy(busy0), .frame_done(frame_done0),
        .vert_addr(vert_addr0), .vert_x(32'd0), .vert_y(32'd0), .vert_z(32'd0),
        .mvp_start(mvp_start0), .mvp_update(mvp_update0), .mvp_x(mvp_x0), .mvp_y(mvp_y0), .mvp_z(mvp_z0),
        .mvp_done(mvp_done0), .mvp_ox(32'd0), .mvp_oy(32'd0), .mvp_oz(32'd0),
        .tri_valid(tri_valid0), .tri_ready(1'b1),
        .tri_x0(t0_x0), .tri_y0(t0_y0), .tri_x1(t0_x1), .tri_y1(t0_y1), .tri_x2(t0_x2), .tri_y2(t0_y2)
    );

    // Vertex table: T0 front, T1 back-facing, T2 all x<0, T3 x=40000, T4 x=-40000, T5 all y>479, T6 degenerate
    logic [31:0] mem_x [256];
    logic [31:0] mem_y [256];
    int tx [3*NT] = '{100, 200, 100,  100, 100, 200,  -50, -10, -1,  100, 40000, 100,
                      -40000, 200, 100,  100, 200, 100,  100, 200, 300};
    int ty [3*NT] = '{100, 100, 200,  100, 200, 100,  100, 100, 200,  100, 100, 200,
                      100, 100, 200,  500, 500, 600,  100, 200, 300};

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
            if (i < 3*NT) begin
                mem_x[i] = 32'(tx[i]);
                mem_y[i] = 32'(ty[i]);
            end
        end
    end

    // Memory with one-cycle read latency, and a pass-through transform stage busy for XF_LAT cycles.
    always @(posedge clock) begin
        vert_x <= mem_x[vert_addr];
        vert_y <= mem_y[vert_addr];
        vert_z <= 32'h3f800000;
        if (mvp_start) begin
            xf_cnt <= XF_LAT;
            xf_ox  <= mvp_x;
            xf_oy  <= mvp_y;
            xf_oz  <= mvp_z;
        end else if (xf_cnt != 0) begin
            xf_cnt <= xf_cnt - 1;
        end
        if (mvp_start0) xf0_cnt <= XF_LAT;
        else if (xf0_cnt != 0) xf0_cnt <= xf0_cnt - 1;
    end

    int          n_checks = 0, n_fail = 0, cyc = 0, fd_count = 0;
    int          fd0_count = 0, upd0_count = 0, valid0_count = 0, t_rise = -1, t_fd = -1;
    logic        prev_done0 = 1'b1, hold_pending = 1'b0;
    logic [95:0] hold_val = '0;
    logic [95:0] exp_q [$];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] tri_pack(input int x0, y0, x1, y1, x2, y2);
        return {16'(x0), 16'(y0), 16'(x1), 16'(y1), 16'(x2), 16'(y2)};
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (mvp_start) check("mvp_start_into_busy_stage", mvp_done, 1);
            if (tri_valid) begin
                check("no_xform_during_emit", mvp_start, 0);
                if (hold_pending) check("tri_stable_while_stalled", tri_obs, hold_val);
                hold_val     = tri_obs;
                hold_pending = !tri_ready;
                if (tri_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_tri: actual %0h, required none", tri_obs);
                    end else begin
                        check("tri", tri_obs, exp_q.pop_front());
                    end
                end
            end else begin
                hold_pending = 1'b0;
            end
            if (frame_done) fd_count++;
        end
        if (mvp_start0) check("nt0_mvp_start_into_busy_stage", mvp_done0, 1);
        if (mvp_start0 && mvp_update0) upd0_count++;
        if (tri_valid0) valid0_count++;
        if (mvp_done0 && !prev_done0) t_rise = cyc;
        if (frame_done0) begin
            t_fd = cyc;
            fd0_count++;
        end
        prev_done0 = mvp_done0;
    end

    task automatic push_frame();
        exp_q.push_back(tri_pack(100, 100, 200, 100, 100, 200));
        exp_q.push_back(tri_pack(100, 100, 32767, 100, 100, 200));
        exp_q.push_back(tri_pack(-32768, 100, 200, 100, 100, 200));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_tri_valid"}, tri_valid, 0);
        check({tag, "_mvp_start"}, mvp_start, 0);
        check({tag, "_mvp_update"}, mvp_update, 0);
        check({tag, "_vert_addr"}, vert_addr, 0);
        check({tag, "_mvp_xyz"}, {mvp_x, mvp_y, mvp_z}, 0);
        check({tag, "_tri_xy"}, tri_obs, 0);
    endtask

    task automatic run_frame(input string name, input bit stall);
        int fd_before = fd_count;
        int stall_cnt = 0;
        int budget = 0;
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        while (fd_count == fd_before && budget < 3000) begin
            frame_start = (budget == 60);
            if (stall && tri_valid && stall_cnt < 20) begin
                tri_ready = 1'b0;
                stall_cnt++;
            end else begin
                tri_ready = 1'b1;
            end
            @(posedge clock); #1;
            budget++;
        end
        frame_start = 1'b0;
        tri_ready   = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check({name, "_frame_done_count"}, fd_count - fd_before, 1);
        check({name, "_all_tris_seen"}, exp_q.size(), 0);
        check({name, "_busy_after"}, busy, 0);
        if (stall) check({name, "_stall_cycles"}, stall_cnt, 20);
    endtask

    initial begin
        int b;
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset");
        reset = 1'b0;

        push_frame();
        run_frame("frame_a", 1'b0);
        push_frame();
        run_frame("frame_b_stall", 1'b1);

        // Abandon a frame while triangle 1 is in the transform stage.
        exp_q.push_back(tri_pack(100, 100, 200, 100, 100, 200));
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        b = 0;
        while (!(vert_addr == 8'd3 && mvp_start) && b < 500) begin
            @(posedge clock); #1;
            b++;
        end
        check("reach_tri1_xform", b < 500, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        check_idle("mid_frame_reset");
        check("tri0_before_reset", exp_q.size(), 0);
        check("no_frame_done_on_abort", fd_count, 2);
        push_frame();
        run_frame("frame_c_restart", 1'b0);

        @(posedge clock); #1 frame_start0 = 1'b1;
        @(posedge clock); #1 frame_start0 = 1'b0;
        check("nt0_busy_during", busy0, 1);
        b = 0;
        while (fd0_count == 0 && b < 200) begin
            @(posedge clock); #1;
            b++;
        end
        repeat (5) @(posedge clock);
        #1;
        check("nt0_frame_done_count", fd0_count, 1);
        check("nt0_update_count", upd0_count, 1);
        check("nt0_done_latency", t_fd, t_rise + 1);
        check("nt0_no_tri", valid0_count, 0);
        check("nt0_busy_after", busy0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
